fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side companion of the team's FIFO. Drains words from a FIFO's pop port and presents them on a valid/ready stream toward a downstream consumer.
- Hides the synchronous-SRAM read latency behind a small credit-tracked output buffer. Sustains one word per cycle when downstream is always ready.
- Sits between the FIFO's pop/empty/popData pins and any stream sink, such as a UART transmitter or a DMA writer.

Parameters:
- bitWidth, 32, data word width; must match the FIFO.
- readLatency, 1, cycles from an accepted pop to valid popData; legal range 1..4.
- bufferDepth (localparam), readLatency+2, output buffer entries; sized for full throughput.

Ports:
- clock  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- fifoEmpty  input  1  empty flag from the FIFO.
- fifoPopData  input  bitWidth  FIFO read data, valid readLatency cycles after an accepted pop.
- fifoPop  output  1  pop request to the FIFO.
- outValid  output  1  stream word available.
- outReady  input  1  consumer accepts the word.
- outData  output  bitWidth  stream word, driven from the buffer head.

Behaviour:
- Accepted pop: fifoPop && !fifoEmpty in a cycle.
- Accepted transfer: outValid && outReady in a cycle.
- Pop issue rule (combinational): fifoPop = !reset && !fifoEmpty && (count + inFlight < bufferDepth).
  - count: occupied buffer entries.
  - inFlight: accepted pops whose data has not yet returned.
- inFlight tracking: a readLatency-deep valid shift register. Bit 0 loads the accepted-pop flag each cycle. When the last stage is 1, fifoPopData is written into the buffer at that edge.
- Credit return: a slot freed by an accepted transfer becomes usable for pop issue in the next cycle, not the same cycle.
- Latency, empty buffer, outReady=1, readLatency=L: pop accepted in cycle t gives outValid=1 with that word in cycle t+L+1.
- Throughput: with outReady held high and the FIFO non-empty, one word per cycle in steady state.
- Ordering: strict FIFO order. No word is dropped or duplicated.
- Stability: while outValid && !outReady, outData and outValid hold unchanged.
- Buffer: circular, bufferDepth entries. Read and write pointers are clog2(bufferDepth) wide with explicit wrap at bufferDepth-1 → 0.
- Simultaneous write and accepted transfer in one cycle: count is unchanged and both pointers advance.
- Full buffer: count == bufferDepth forces fifoPop=0. The credit rule guarantees no overflow even with inFlight>0.
- fifoEmpty high: no pop is issued. Words already in flight still land and are delivered.
- Reset values (apply at any time, including mid-operation):
  - count=0, inFlight shift register=0, pointers=0.
  - outValid=0, fifoPop=0, outData=0.
  - In-flight and buffered words are discarded, because the FIFO is reset together with this block.
- First cycle after reset deasserts: fifoPop may assert in that cycle if fifoEmpty=0.

Optional Feature:
- Macro: FIFO_STREAM_READER_STATS_EN.
- Defined: adds two 32-bit outputs.
  - wordCount: increments on each accepted transfer.
  - stallCount: increments each cycle with outValid && !outReady.
  - Both clear on reset and wrap modulo 2^32.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package fifo_stream_pkg:
  - DEFAULT_BIT_WIDTH=32.
  - DEFAULT_READ_LATENCY=1.
  - A function computing bufferDepth from readLatency.
- One natural sub-module, fifo_stream_outbuf: the circular buffer with count, pointers, write-enable, and the valid/ready output side.
- The top level keeps the pop-issue logic, the inFlight shift register and the optional stats.

Test Plan:
- Reset, then FIFO preloaded with 0xA0..0xA7, outReady=1, L=1 → fifoPop high for 8 consecutive cycles; outData yields 0xA0..0xA7 in order, one per cycle, first word exactly 2 cycles after the first pop.
- 6 words queued, outReady=0 → fifoPop stops after 3 pops (bufferDepth=3). outValid=1 with outData=first word held stable; once outReady=1, all 6 words delivered in order.
- outReady toggling 1,0,1,0 with 10 words → no loss or duplication. count never exceeds 3; fifoPop never asserted when count+inFlight=3.
- fifoEmpty=1 for 5 cycles mid-stream → fifoPop=0 throughout; remaining buffered words drain and outValid falls to 0 when count reaches 0.
- Reset asserted with 2 words buffered and 1 in flight → next cycle outValid=0, fifoPop=0, count=0; in-flight word never appears on outData.
- With FIFO_STREAM_READER_STATS_EN and readLatency=3, 20 words, outReady low for 4 cycles → wordCount=20, stallCount=4; full throughput restored once outReady=1.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared constants and the buffer sizing rule for the FIFO stream reader.
package fifo_stream_pkg;

   localparam int DEFAULT_BIT_WIDTH    = 32;
   localparam int DEFAULT_READ_LATENCY = 1;

   // Two entries beyond the read latency keep one word per cycle flowing
   // while the freed slot's credit takes a cycle to come back.
   function automatic int calc_buffer_depth(input int readLatency);
      return readLatency + 2;
   endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO pop pins plus the outgoing valid/ready stream; master is the reader.
interface fifo_stream_reader_if
   import fifo_stream_pkg::*;
#(
   parameter int bitWidth = DEFAULT_BIT_WIDTH
);

   logic                fifoEmpty;
   logic [bitWidth-1:0] fifoPopData;
   logic                fifoPop;
   logic                outValid;
   logic                outReady;
   logic [bitWidth-1:0] outData;

   modport master (
      input  fifoEmpty, fifoPopData, outReady,
      output fifoPop, outValid, outData
   );

   modport slave (
      output fifoEmpty, fifoPopData, outReady,
      input  fifoPop, outValid, outData
   );

endinterface

// File: rtl/fifo_stream_outbuf.sv
// Circular output buffer: landing FIFO words are queued and offered head-first
// on the valid/ready side.
module fifo_stream_outbuf
   import fifo_stream_pkg::*;
#(
   parameter int bitWidth = DEFAULT_BIT_WIDTH,
   parameter int depth    = 3
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         wrEn,
   input  logic [bitWidth-1:0]          wrData,
   output logic                         outValid,
   input  logic                         outReady,
   output logic [bitWidth-1:0]          outData,
   output logic [$clog2(depth + 1)-1:0] count
);

   localparam int PTR_W = $clog2(depth);
   localparam int CNT_W = $clog2(depth + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(depth - 1);

   logic [bitWidth-1:0] mem_q [depth];
   logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                xfer;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign outValid = (count_q != '0);
   assign xfer     = outValid && outReady;
   // Empty buffer presents zero so a fresh reset shows a clean bus.
   assign outData  = outValid ? mem_q[rdPtr_q] : '0;
   assign count    = count_q;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (wrEn) wrPtr_d = ptr_inc(wrPtr_q);
      if (xfer) rdPtr_d = ptr_inc(rdPtr_q);
      case ({wrEn, xfer})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wrEn) mem_q[wrPtr_q] <= wrData;
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO pop port into a valid/ready stream, hiding SRAM read latency.
// Define FIFO_STREAM_READER_STATS_EN to add wordCount/stallCount outputs.
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int bitWidth    = DEFAULT_BIT_WIDTH,
   parameter int readLatency = DEFAULT_READ_LATENCY
) (
   input  logic                 clock,
   input  logic                 reset,
   fifo_stream_reader_if.master bus
`ifdef FIFO_STREAM_READER_STATS_EN
   ,
   output logic [31:0]          wordCount,
   output logic [31:0]          stallCount
`endif
);

   localparam int bufferDepth = calc_buffer_depth(readLatency);
   localparam int CNT_W       = $clog2(bufferDepth + 1);
   localparam int OCC_W       = $clog2(bufferDepth + readLatency + 1);

   if (readLatency < 1 || readLatency > 4) begin : g_bad_latency
      $error("fifo_stream_reader: readLatency must be 1..4");
   end

   logic [readLatency-1:0] inFlight_q, inFlight_d;
   logic [CNT_W-1:0]       count;
   logic [OCC_W-1:0]       occupancy;
   logic                   popAccept;

   // Registered count only: a slot freed this cycle is reusable next cycle.
   always_comb begin
      occupancy = OCC_W'(count);
      for (int i = 0; i < readLatency; i++) begin
         occupancy = occupancy + OCC_W'(inFlight_q[i]);
      end
   end

   assign bus.fifoPop = !reset && !bus.fifoEmpty && (occupancy < OCC_W'(bufferDepth));
   assign popAccept   = bus.fifoPop && !bus.fifoEmpty;

   always_comb begin
      inFlight_d    = '0;
      inFlight_d[0] = popAccept;
      for (int i = 1; i < readLatency; i++) begin
         inFlight_d[i] = inFlight_q[i-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) inFlight_q <= '0;
      else       inFlight_q <= inFlight_d;
   end

   fifo_stream_outbuf #(
      .bitWidth (bitWidth),
      .depth    (bufferDepth)
   ) u_outbuf (
      .clock    (clock),
      .reset    (reset),
      .wrEn     (inFlight_q[readLatency-1]),
      .wrData   (bus.fifoPopData),
      .outValid (bus.outValid),
      .outReady (bus.outReady),
      .outData  (bus.outData),
      .count    (count)
   );

`ifdef FIFO_STREAM_READER_STATS_EN
   logic [31:0] wordCount_q, stallCount_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         wordCount_q  <= '0;
         stallCount_q <= '0;
      end else begin
         if (bus.outValid && bus.outReady)  wordCount_q  <= wordCount_q + 32'd1;
         if (bus.outValid && !bus.outReady) stallCount_q <= stallCount_q + 32'd1;
      end
   end

   assign wordCount  = wordCount_q;
   assign stallCount = stallCount_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a FIFO model and stream scoreboard.
module tb_fifo_stream_reader;
   import fifo_stream_pkg::*;

`ifdef FIFO_STREAM_READER_STATS_EN
   localparam int TB_LAT = 3;
`else
   localparam int TB_LAT = 1;
`endif
   localparam int DEPTH = TB_LAT + 2;
   localparam int BW    = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_stream_reader_if #(.bitWidth(BW)) bus ();

`ifdef FIFO_STREAM_READER_STATS_EN
   logic [31:0] wordCount, stallCount;
`endif

   fifo_stream_reader #(
      .bitWidth    (BW),
      .readLatency (TB_LAT)
   ) dut (
      .clock      (clk),
      .reset      (rst),
`ifdef FIFO_STREAM_READER_STATS_EN
      .wordCount  (wordCount),
      .stallCount (stallCount),
`endif
      .bus        (bus)
   );

   typedef struct {
      logic        rdy;
      logic        pop;
      logic        vld;
      logic [31:0] data;
   } vec_t;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] fq[$];
   logic [31:0] exp_q[$];
   logic [31:0] pd [TB_LAT];
   bit          force_empty = 1'b0;
   int          pops = 0;
   int          xfers = 0;
   logic        s_pop, s_vld, s_rdy, s_empty;
   logic [31:0] s_data;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_empty();
      bus.fifoEmpty = force_empty || (fq.size() == 0);
   endtask

   // One clock: sample at negedge, check protocol, then advance the FIFO model.
   task automatic step_cycle();
      int outstanding;
      @(negedge clk);
      s_pop   = bus.fifoPop;
      s_vld   = bus.outValid;
      s_rdy   = bus.outReady;
      s_empty = bus.fifoEmpty;
      s_data  = bus.outData;
      if (!rst) begin
         outstanding = pops - xfers;
         if (s_empty) check("pop_while_empty", 32'(s_pop), 0);
         if (s_pop)   check("pop_credit", 32'(outstanding < DEPTH), 1);
         if (prev_stall) begin
            check("hold_valid", 32'(s_vld), 1);
            check("hold_data", s_data, prev_data);
         end
         if (s_vld && s_rdy) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL spurious_word: got %0h, want no transfer at %0t", s_data, $time);
            end else begin
               check("order", s_data, exp_q.pop_front());
            end
         end
         prev_stall = s_vld && !s_rdy;
         prev_data  = s_data;
      end else begin
         prev_stall = 1'b0;
      end
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         pops  = 0;
         xfers = 0;
         for (int i = 0; i < TB_LAT; i++) pd[i] = '0;
      end else begin
         for (int i = TB_LAT - 1; i > 0; i--) pd[i] = pd[i-1];
         pd[0] = '0;
         if (s_pop && !s_empty) begin
            pd[0] = fq.pop_front();
            exp_q.push_back(pd[0]);
            pops++;
         end
         if (s_vld && s_rdy) xfers++;
      end
      #1;
      bus.fifoPopData = pd[TB_LAT-1];
      drive_empty();
   endtask

   task automatic drain(input int n, input int budget, output int got);
      got = 0;
      for (int c = 0; c < budget && got < n; c++) begin
         step_cycle();
         if (s_vld && s_rdy) got++;
      end
   endtask

   initial begin
      vec_t tbl[$];
      int   got, n2, npop, cyc, rem;

      for (int i = 0; i < TB_LAT; i++) pd[i] = '0;
      bus.outReady    = 1'b0;
      bus.fifoPopData = '0;
      for (int i = 0; i < 8; i++) fq.push_back(32'hA0 + 32'(i));
      drive_empty();

      // Reset with a non-empty FIFO: nothing may be popped or offered.
      rst = 1'b1;
      repeat (3) step_cycle();
      check("rst_pop", 32'(s_pop), 0);
      check("rst_valid", 32'(s_vld), 0);
      check("rst_data", s_data, 0);
`ifdef FIFO_STREAM_READER_STATS_EN
      check("rst_wordCount", wordCount, 0);
      check("rst_stallCount", stallCount, 0);
`endif
      rst = 1'b0;

      // Preloaded A0..A7, outReady high: back-to-back pops and words.
`ifdef FIFO_STREAM_READER_STATS_EN
      tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hA0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hA1});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hA2});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hA3});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 32'hA4});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 32'hA5});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 32'hA6});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 32'hA7});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0});
`else
      tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hA0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hA1});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hA2});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hA3});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hA4});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hA5});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 32'hA6});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 32'hA7});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0});
`endif
      foreach (tbl[i]) begin
         bus.outReady = tbl[i].rdy;
         step_cycle();
         check("t1_pop", 32'(s_pop), 32'(tbl[i].pop));
         check("t1_valid", 32'(s_vld), 32'(tbl[i].vld));
         if (tbl[i].vld) check("t1_data", s_data, tbl[i].data);
      end
      check("t1_all_delivered", 32'(exp_q.size()), 0);

      // Six words, consumer stalled: only DEPTH pops, head word held.
      bus.outReady = 1'b0;
      for (int i = 0; i < 6; i++) fq.push_back(32'hB0 + 32'(i));
      drive_empty();
      npop = 0;
      repeat (DEPTH + 4) begin
         step_cycle();
         if (s_pop) npop++;
      end
      check("t2_pops_while_stalled", 32'(npop), 32'(DEPTH));
      check("t2_valid", 32'(s_vld), 1);
      check("t2_head", s_data, 32'hB0);
      bus.outReady = 1'b1;
      drain(6, 40, got);
      check("t2_delivered", 32'(got), 6);

      // Ten words with outReady alternating 1,0,1,0.
      for (int i = 0; i < 10; i++) fq.push_back(32'hC0 + 32'(i));
      drive_empty();
      got = 0;
      for (int c = 0; c < 80 && got < 10; c++) begin
         bus.outReady = (c % 2 == 0);
         step_cycle();
         if (s_vld && s_rdy) got++;
      end
      check("t3_delivered", 32'(got), 10);
      check("t3_scoreboard_empty", 32'(exp_q.size()), 0);

      // FIFO reports empty for 5 cycles mid-stream.
      bus.outReady = 1'b1;
      for (int i = 0; i < 8; i++) fq.push_back(32'hD0 + 32'(i));
      drive_empty();
      got = 0;
      repeat (3) begin
         step_cycle();
         if (s_vld && s_rdy) got++;
      end
      force_empty = 1'b1;
      drive_empty();
      repeat (5) begin
         step_cycle();
         check("t4_no_pop", 32'(s_pop), 0);
         if (s_vld && s_rdy) got++;
      end
      check("t4_drained_valid", 32'(s_vld), 0);
      force_empty = 1'b0;
      drive_empty();
      drain(8 - got, 40, n2);
      got += n2;
      check("t4_delivered", 32'(got), 8);

      // Reset with two words buffered and one in flight.
      bus.outReady = 1'b0;
      for (int i = 0; i < 3; i++) fq.push_back(32'hE0 + 32'(i));
      drive_empty();
      repeat (TB_LAT + 2) step_cycle();
      check("t5_pre_valid", 32'(s_vld), 1);
      check("t5_pre_head", s_data, 32'hE0);
      rst = 1'b1;
      step_cycle();
      rst = 1'b0;
      step_cycle();
      check("t5_valid", 32'(s_vld), 0);
      check("t5_pop", 32'(s_pop), 0);
      check("t5_data", s_data, 0);
      fq.push_back(32'hF0);
      fq.push_back(32'hF1);
      drive_empty();
      bus.outReady = 1'b1;
      drain(2, 20, got);
      check("t5_delivered", 32'(got), 2);

`ifdef FIFO_STREAM_READER_STATS_EN
      // Twenty words, four stall cycles, then full rate again.
      rst = 1'b1;
      step_cycle();
      rst = 1'b0;
      check("t6_rst_wordCount", wordCount, 0);
      check("t6_rst_stallCount", stallCount, 0);
      for (int i = 0; i < 20; i++) fq.push_back(32'h100 + 32'(i));
      drive_empty();
      bus.outReady = 1'b1;
      got = 0;
      repeat (TB_LAT + 3) begin
         step_cycle();
         if (s_vld && s_rdy) got++;
      end
      bus.outReady = 1'b0;
      repeat (4) step_cycle();
      bus.outReady = 1'b1;
      rem = 20 - got;
      n2  = 0;
      cyc = 0;
      while (n2 < rem && cyc < 60) begin
         step_cycle();
         cyc++;
         if (s_vld && s_rdy) n2++;
      end
      check("t6_delivered", 32'(n2), 32'(rem));
      check("t6_full_rate", 32'(cyc), 32'(rem));
      check("t6_wordCount", wordCount, 20);
      check("t6_stallCount", stallCount, 4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
